// File: rtl/mcs51_int_pkg.sv
// mcs51_int_pkg
// Shared definitions for the MCS-51 interrupt controller: interrupt source
// indices, LCALL vector constants, default SFR addresses, writable-bit masks
// for IE/IP and the request/acknowledge FSM state type.
// Optional feature macro: INT_CTRL_TIMER2_EN (adds the Timer 2 source).
package mcs51_int_pkg;

    localparam int NUM_SRC = 6;

    // Source index doubles as the polling order (lower index polls first).
    typedef enum logic [2:0] {
        SRC_IE0   = 3'd0,
        SRC_TF0   = 3'd1,
        SRC_IE1   = 3'd2,
        SRC_TF1   = 3'd3,
        SRC_UART0 = 3'd4,
        SRC_TF2   = 3'd5
    } src_t;

    localparam logic [15:0] VEC_IE0   = 16'h0003;
    localparam logic [15:0] VEC_TF0   = 16'h000B;
    localparam logic [15:0] VEC_IE1   = 16'h0013;
    localparam logic [15:0] VEC_TF1   = 16'h001B;
    localparam logic [15:0] VEC_UART0 = 16'h0023;
    localparam logic [15:0] VEC_TF2   = 16'h002B;

    localparam logic [7:0] IE_ADDR_DEFAULT = 8'hA8;
    localparam logic [7:0] IP_ADDR_DEFAULT = 8'hB8;

    // Bits that actually exist in IE/IP; everything else stores and reads 0.
`ifdef INT_CTRL_TIMER2_EN
    localparam logic [7:0] IE_MASK = 8'hBF;
    localparam logic [7:0] IP_MASK = 8'h3F;
`else
    localparam logic [7:0] IE_MASK = 8'h9F;
    localparam logic [7:0] IP_MASK = 8'h1F;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    function automatic logic [15:0] vector_of(src_t src);
        logic [15:0] vec;
        case (src)
            SRC_IE0:   vec = VEC_IE0;
            SRC_TF0:   vec = VEC_TF0;
            SRC_IE1:   vec = VEC_IE1;
            SRC_TF1:   vec = VEC_TF1;
            SRC_UART0: vec = VEC_UART0;
            SRC_TF2:   vec = VEC_TF2;
            default:   vec = VEC_IE0;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/mcs51_int_arb.sv
// mcs51_int_arb
// Combinational priority selection between eligible interrupt sources.
// Ports:
//   req    [5:0] in  eligible (already masked) requests, indexed by src_t
//   ip     [5:0] in  IP priority bits, 1 = high level
//   winner [2:0] out index of the selected source
//   valid        out at least one request present
module mcs51_int_arb
    import mcs51_int_pkg::*;
(
    input  logic [5:0] req,
    input  logic [5:0] ip,
    output logic [2:0] winner,
    output logic       valid
);

    logic [5:0] high_req;
    logic [5:0] cand;

    // High-level requests shadow all low-level ones; within the chosen
    // group the lowest index wins, so the loop runs downward and the last
    // hit (lowest index) is the one that sticks.
    always_comb begin
        high_req = req & ip;
        cand     = (|high_req) ? high_req : req;
        valid    = |req;
        winner   = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                winner = i[2:0];
            end
        end
    end

endmodule

// File: rtl/mcs51_int_ctrl.sv
// mcs51_int_ctrl
// MCS-51 style interrupt controller: IE/IP SFRs on the Naive-Memory bus,
// two-level in-service tracking and a request/acknowledge handshake with the
// CPU core.
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   mem_sel/we_n/rd_n/sfr_n       bus strobes
//   mem_addr[15:0], mem_wdata[7:0] bus address / write data
//   mem_rdata[7:0], mem_ready_out bus read data / transfer complete
//   int_exIO0..int_UART0 (+int_TF2) level requests from peripherals
//   int_resp_n[7:0]               per-source acknowledge, active-low
//   irq_req, irq_vector[15:0]     request and LCALL target to the core
//   irq_ack, irq_reti             core pulses: vector fetched / RETI
// Optional feature macro: INT_CTRL_TIMER2_EN (adds int_TF2 and IE[5]/IP[5]).
module mcs51_int_ctrl
    import mcs51_int_pkg::*;
#(
    parameter logic [7:0] IE_ADDR = IE_ADDR_DEFAULT,
    parameter logic [7:0] IP_ADDR = IP_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_sel,
    input  logic        mem_we_n,
    input  logic        mem_rd_n,
    input  logic        mem_sfr_n,
    input  logic [15:0] mem_addr,
    input  logic [7:0]  mem_wdata,
    output logic [7:0]  mem_rdata,
    output logic        mem_ready_out,
    input  logic        int_exIO0,
    input  logic        int_TF0,
    input  logic        int_exIO1,
    input  logic        int_TF1,
    input  logic        int_UART0,
`ifdef INT_CTRL_TIMER2_EN
    input  logic        int_TF2,
`endif
    output logic [7:0]  int_resp_n,
    output logic        irq_req,
    output logic [15:0] irq_vector,
    input  logic        irq_ack,
    input  logic        irq_reti
);

    logic [7:0]  ie_q, ip_q;
    logic        isr_high_q, isr_low_q;
    logic        isr_high_d, isr_low_d;
    state_t      state_q, state_d;
    src_t        winner_q, winner_d;
    logic [15:0] vector_q, vector_d;
    logic        ack_set;
    logic [5:0]  raw_req, level_ok, eligible;
    logic [2:0]  arb_winner;
    logic        arb_valid;
    logic        tf2_req;
    logic        sfr_hit, ie_hit, ip_hit;
    logic        unused_addr;

`ifdef INT_CTRL_TIMER2_EN
    assign tf2_req = int_TF2;
`else
    assign tf2_req = 1'b0;
`endif

    assign unused_addr = ^mem_addr[15:8];

    assign sfr_hit       = mem_sel & ~mem_sfr_n;
    assign ie_hit        = sfr_hit && (mem_addr[7:0] == IE_ADDR);
    assign ip_hit        = sfr_hit && (mem_addr[7:0] == IP_ADDR);
    assign mem_ready_out = mem_sel;

    // Read data is purely combinational; stored registers are already
    // masked so unimplemented bits come back as 0.
    always_comb begin
        mem_rdata = 8'h00;
        if (!mem_rd_n) begin
            if (ie_hit) begin
                mem_rdata = ie_q;
            end else if (ip_hit) begin
                mem_rdata = ip_q;
            end
        end
    end

    // A high-level source only needs the high in-service bit clear; a
    // low-level source needs nothing at all in service.
    assign raw_req  = {tf2_req, int_UART0, int_TF1, int_exIO1, int_TF0, int_exIO0};
    assign level_ok = (ip_q[5:0] & {6{~isr_high_q}})
                    | (~ip_q[5:0] & {6{~(isr_high_q | isr_low_q)}});
    assign eligible = raw_req & ie_q[5:0] & {6{ie_q[7]}} & level_ok;

    mcs51_int_arb u_arb (
        .req    (eligible),
        .ip     (ip_q[5:0]),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    // Next-state and handshake outputs. The latched winner and vector stay
    // frozen through REQ so a later, higher-priority source cannot disturb a
    // vector the core may already be fetching.
    always_comb begin
        state_d    = state_q;
        winner_d   = winner_q;
        vector_d   = vector_q;
        ack_set    = 1'b0;
        irq_req    = 1'b0;
        irq_vector = 16'h0000;
        int_resp_n = 8'hFF;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    winner_d = src_t'(arb_winner);
                    vector_d = vector_of(src_t'(arb_winner));
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                irq_req    = 1'b1;
                irq_vector = vector_q;
                if (irq_ack) begin
                    ack_set = 1'b1;
                    state_d = ST_ACK;
                end else if (!eligible[winner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                int_resp_n[winner_q] = 1'b0;
                state_d              = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // RETI releases the innermost level before an ack in the same cycle
    // marks the new one, so a simultaneous pair nets out correctly.
    always_comb begin
        isr_high_d = isr_high_q;
        isr_low_d  = isr_low_q;
        if (irq_reti) begin
            if (isr_high_q) begin
                isr_high_d = 1'b0;
            end else begin
                isr_low_d = 1'b0;
            end
        end
        if (ack_set) begin
            if (ip_q[winner_q]) begin
                isr_high_d = 1'b1;
            end else begin
                isr_low_d = 1'b1;
            end
        end
    end

    // State, in-service bits and SFRs; reset drops any pending request or
    // acknowledge without emitting a response pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            winner_q   <= SRC_IE0;
            vector_q   <= 16'h0000;
            isr_high_q <= 1'b0;
            isr_low_q  <= 1'b0;
            ie_q       <= 8'h00;
            ip_q       <= 8'h00;
        end else begin
            state_q    <= state_d;
            winner_q   <= winner_d;
            vector_q   <= vector_d;
            isr_high_q <= isr_high_d;
            isr_low_q  <= isr_low_d;
            if (!mem_we_n && ie_hit) begin
                ie_q <= mem_wdata & IE_MASK;
            end
            if (!mem_we_n && ip_hit) begin
                ip_q <= mem_wdata & IP_MASK;
            end
        end
    end

endmodule

// File: tb/tb_mcs51_int_ctrl.sv
// tb_mcs51_int_ctrl
// Self-checking bench for mcs51_int_ctrl: a protocol-level model (nesting
// stack of in-service levels, best-source search) is compared against the
// DUT every cycle, plus directed scenarios with literal expectations.
// Optional feature macro: INT_CTRL_TIMER2_EN.
module tb_mcs51_int_ctrl;

    localparam logic [7:0] A_IE = 8'hA8;
    localparam logic [7:0] A_IP = 8'hB8;
`ifdef INT_CTRL_TIMER2_EN
    localparam logic [7:0] M_IE = 8'hBF;
    localparam logic [7:0] M_IP = 8'h3F;
`else
    localparam logic [7:0] M_IE = 8'h9F;
    localparam logic [7:0] M_IP = 8'h1F;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_sel, mem_we_n, mem_rd_n, mem_sfr_n;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready_out;
    logic        int_exIO0, int_TF0, int_exIO1, int_TF1, int_UART0, int_TF2;
    logic [7:0]  int_resp_n;
    logic        irq_req;
    logic [15:0] irq_vector;
    logic        irq_ack, irq_reti;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mcs51_int_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem_sel       (mem_sel),
        .mem_we_n      (mem_we_n),
        .mem_rd_n      (mem_rd_n),
        .mem_sfr_n     (mem_sfr_n),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ready_out (mem_ready_out),
        .int_exIO0     (int_exIO0),
        .int_TF0       (int_TF0),
        .int_exIO1     (int_exIO1),
        .int_TF1       (int_TF1),
        .int_UART0     (int_UART0),
`ifdef INT_CTRL_TIMER2_EN
        .int_TF2       (int_TF2),
`endif
        .int_resp_n    (int_resp_n),
        .irq_req       (irq_req),
        .irq_vector    (irq_vector),
        .irq_ack       (irq_ack),
        .irq_reti      (irq_reti)
    );

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = nothing pending, 1 = requesting the core, 2 = acknowledging
    int         m_phase = 0;
    int         m_win = 0;
    int         m_stack[$];
    logic [7:0] m_ie = 8'h00;
    logic [7:0] m_ip = 8'h00;
    bit         model_valid = 0;

    function automatic int src_level(int s);
        return m_ip[s] ? 2 : 1;
    endfunction

    function automatic int cur_level();
        return (m_stack.size() == 0) ? 0 : m_stack[m_stack.size() - 1];
    endfunction

    function automatic bit src_eligible(int s);
        logic [5:0] r;
        r = {int_TF2, int_UART0, int_TF1, int_exIO1, int_TF0, int_exIO0};
        return r[s] && m_ie[s] && m_ie[7] && (src_level(s) > cur_level());
    endfunction

    function automatic logic [7:0] exp_rdata();
        if (mem_sel && !mem_sfr_n && !mem_rd_n) begin
            if (mem_addr[7:0] == A_IE) return m_ie;
            if (mem_addr[7:0] == A_IP) return m_ip;
        end
        return 8'h00;
    endfunction

    task automatic model_step();
        bit el[6];
        int best;
        bit reti_done;
        if (!reset_n) begin
            m_ie = 8'h00;
            m_ip = 8'h00;
            m_stack.delete();
            m_phase = 0;
            m_win = 0;
            model_valid = 1;
            return;
        end
        reti_done = 0;
        for (int s = 0; s < 6; s++) el[s] = src_eligible(s);
        case (m_phase)
            0: begin
                best = -1;
                for (int s = 0; s < 6; s++)
                    if (el[s] && (best < 0 || src_level(s) > src_level(best))) best = s;
                if (best >= 0) begin
                    m_win = best;
                    m_phase = 1;
                end
            end
            1: begin
                if (irq_ack) begin
                    if (irq_reti && m_stack.size() > 0) void'(m_stack.pop_back());
                    reti_done = 1;
                    m_stack.push_back(src_level(m_win));
                    m_phase = 2;
                end else if (!el[m_win]) begin
                    m_phase = 0;
                end
            end
            default: m_phase = 0;
        endcase
        if (irq_reti && !reti_done && m_stack.size() > 0) void'(m_stack.pop_back());
        if (mem_sel && !mem_sfr_n && !mem_we_n) begin
            if (mem_addr[7:0] == A_IE) m_ie = mem_wdata & M_IE;
            if (mem_addr[7:0] == A_IP) m_ip = mem_wdata & M_IP;
        end
    endtask

    always @(posedge clk) model_step();

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("irq_req", {15'h0, irq_req}, {15'h0, m_phase == 1});
            checkOutput("irq_vector", irq_vector,
                        (m_phase == 1) ? 16'(m_win * 8 + 3) : 16'h0000);
            checkOutput("int_resp_n", {8'h00, int_resp_n},
                        {8'h00, (m_phase == 2) ? 8'(~(8'h01 << m_win)) : 8'hFF});
            checkOutput("mem_rdata", {8'h00, mem_rdata}, {8'h00, exp_rdata()});
            checkOutput("mem_ready_out", {15'h0, mem_ready_out}, {15'h0, mem_sel});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic sel, input logic we_n, input logic rd_n,
                                 input logic sfr_n, input logic [7:0] addr,
                                 input logic [7:0] wdata);
        mem_sel   = sel;
        mem_we_n  = we_n;
        mem_rd_n  = rd_n;
        mem_sfr_n = sfr_n;
        mem_addr  = {8'h00, addr};
        mem_wdata = wdata;
        step();
    endtask

    task automatic sfrWrite(input logic [7:0] addr, input logic [7:0] data);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, addr, data);
    endtask

    task automatic sfrRead(input logic [7:0] addr);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, addr, 8'h00);
    endtask

    task automatic busIdle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
    endtask

    task automatic pulseAck();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    task automatic pulseReti();
        irq_reti = 1'b1;
        step();
        irq_reti = 1'b0;
    endtask

    task automatic waitReq(input int max_cycles, input string name);
        int n = 0;
        while (!irq_req && n < max_cycles) begin
            step();
            n++;
        end
        checkOutput(name, {15'h0, irq_req}, 16'h0001);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        reset_n = 1'b0;
        mem_sel = 1'b0; mem_we_n = 1'b1; mem_rd_n = 1'b1; mem_sfr_n = 1'b1;
        mem_addr = 16'h0000; mem_wdata = 8'h00;
        int_exIO0 = 1'b0; int_TF0 = 1'b0; int_exIO1 = 1'b0; int_TF1 = 1'b0;
        int_UART0 = 1'b0; int_TF2 = 1'b0;
        irq_ack = 1'b0; irq_reti = 1'b0;

        repeat (3) step();
        checkOutput("reset_irq_req", {15'h0, irq_req}, 16'h0000);
        checkOutput("reset_irq_vector", irq_vector, 16'h0000);
        checkOutput("reset_int_resp_n", {8'h00, int_resp_n}, 16'h00FF);
        reset_n = 1'b1;
        step();

        // SFR read-back, unimplemented bits, non-matching address
        sfrWrite(A_IE, 8'hFF);
        sfrRead(A_IE);
`ifdef INT_CTRL_TIMER2_EN
        checkOutput("read_ie_all", {8'h00, mem_rdata}, 16'h00BF);
`else
        checkOutput("read_ie_all", {8'h00, mem_rdata}, 16'h009F);
`endif
        checkOutput("ready_on_sel", {15'h0, mem_ready_out}, 16'h0001);
        sfrRead(8'h90);
        checkOutput("read_unmapped", {8'h00, mem_rdata}, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, A_IE, 8'h00);
        checkOutput("read_non_sfr", {8'h00, mem_rdata}, 16'h0000);
        sfrWrite(A_IP, 8'hFF);
        sfrRead(A_IP);
        checkOutput("read_ip_all", {8'h00, mem_rdata}, {8'h00, M_IP});
        busIdle();
        checkOutput("ready_idle", {15'h0, mem_ready_out}, 16'h0000);
        sfrWrite(A_IE, 8'h00);
        sfrWrite(A_IP, 8'h00);

        // Single TF0 request, ack and response pulse
        sfrWrite(A_IE, 8'h82);
        int_TF0 = 1'b1;
        busIdle();
        checkOutput("tf0_req", {15'h0, irq_req}, 16'h0001);
        checkOutput("tf0_vector", irq_vector, 16'h000B);
        pulseAck();
        int_TF0 = 1'b0;
        checkOutput("tf0_resp", {8'h00, int_resp_n}, 16'h00FD);
        step();
        checkOutput("tf0_resp_one_cycle", {8'h00, int_resp_n}, 16'h00FF);
        pulseReti();

        // IE0 and UART0 together; ack coincides with IE0 dropping
        sfrWrite(A_IE, 8'h9F);
        sfrWrite(A_IP, 8'h00);
        int_exIO0 = 1'b1;
        int_UART0 = 1'b1;
        busIdle();
        checkOutput("ie0_first_vector", irq_vector, 16'h0003);
        int_exIO0 = 1'b0;
        pulseAck();
        checkOutput("ie0_resp", {8'h00, int_resp_n}, 16'h00FE);
        step();
        step();
        checkOutput("uart_blocked_same_level", {15'h0, irq_req}, 16'h0000);
        pulseReti();
        waitReq(4, "uart_after_reti");
        checkOutput("uart_vector", irq_vector, 16'h0023);
        pulseAck();
        int_UART0 = 1'b0;
        checkOutput("uart_resp", {8'h00, int_resp_n}, 16'h00EF);
        pulseReti();

        // High-level TF1 preempts low TF0; low IE0 waits for two RETIs
        sfrWrite(A_IE, 8'h8F);
        sfrWrite(A_IP, 8'h00);
        int_TF0 = 1'b1;
        busIdle();
        checkOutput("nest_tf0_vector", irq_vector, 16'h000B);
        pulseAck();
        int_TF0 = 1'b0;
        int_exIO0 = 1'b1;
        sfrWrite(A_IP, 8'h08);
        int_TF1 = 1'b1;
        busIdle();
        checkOutput("preempt_req", {15'h0, irq_req}, 16'h0001);
        checkOutput("preempt_vector", irq_vector, 16'h001B);
        pulseAck();
        int_TF1 = 1'b0;
        checkOutput("preempt_resp", {8'h00, int_resp_n}, 16'h00F7);
        step();
        step();
        checkOutput("ie0_pending_nested", {15'h0, irq_req}, 16'h0000);
        pulseReti();
        step();
        step();
        checkOutput("ie0_pending_one_reti", {15'h0, irq_req}, 16'h0000);
        pulseReti();
        waitReq(4, "ie0_after_two_reti");
        checkOutput("ie0_late_vector", irq_vector, 16'h0003);
        pulseAck();
        int_exIO0 = 1'b0;
        pulseReti();

        // Request withdrawn by clearing IE while in REQ, no ack
        sfrWrite(A_IE, 8'h88);
        sfrWrite(A_IP, 8'h00);
        int_TF1 = 1'b1;
        busIdle();
        checkOutput("withdraw_vector", irq_vector, 16'h001B);
        sfrWrite(A_IE, 8'h00);
        busIdle();
        checkOutput("withdraw_req_low", {15'h0, irq_req}, 16'h0000);
        checkOutput("withdraw_no_resp", {8'h00, int_resp_n}, 16'h00FF);
        int_TF1 = 1'b0;
        step();
        checkOutput("withdraw_no_resp_later", {8'h00, int_resp_n}, 16'h00FF);

        // SFR write together with ack; then RETI together with ack
        sfrWrite(A_IE, 8'h82);
        int_TF0 = 1'b1;
        busIdle();
        irq_ack = 1'b1;
        sfrWrite(A_IE, 8'h8A);
        irq_ack = 1'b0;
        int_TF0 = 1'b0;
        checkOutput("ack_with_write_resp", {8'h00, int_resp_n}, 16'h00FD);
        sfrRead(A_IE);
        checkOutput("ack_with_write_ie", {8'h00, mem_rdata}, 16'h008A);
        sfrWrite(A_IP, 8'h08);
        int_TF1 = 1'b1;
        busIdle();
        checkOutput("reti_ack_vector", irq_vector, 16'h001B);
        irq_ack = 1'b1;
        irq_reti = 1'b1;
        step();
        irq_ack = 1'b0;
        irq_reti = 1'b0;
        int_TF1 = 1'b0;
        checkOutput("reti_ack_resp", {8'h00, int_resp_n}, 16'h00F7);
        step();
        pulseReti();
        int_TF0 = 1'b1;
        waitReq(4, "tf0_after_reti_ack");
        checkOutput("tf0_after_reti_ack_vec", irq_vector, 16'h000B);
        pulseAck();
        int_TF0 = 1'b0;
        pulseReti();

        // Stray RETI, then reset during REQ and during the ack cycle
        pulseReti();
        step();
        sfrWrite(A_IE, 8'h82);
        sfrWrite(A_IP, 8'h00);
        int_TF0 = 1'b1;
        busIdle();
        checkOutput("pre_reset_req", {15'h0, irq_req}, 16'h0001);
        reset_n = 1'b0;
        step();
        checkOutput("reset_in_req", {15'h0, irq_req}, 16'h0000);
        checkOutput("reset_in_req_resp", {8'h00, int_resp_n}, 16'h00FF);
        reset_n = 1'b1;
        step();
        checkOutput("after_reset_resp", {8'h00, int_resp_n}, 16'h00FF);
        sfrRead(A_IE);
        checkOutput("after_reset_ie", {8'h00, mem_rdata}, 16'h0000);
        sfrWrite(A_IE, 8'h82);
        busIdle();
        checkOutput("pre_reset_ack_req", {15'h0, irq_req}, 16'h0001);
        irq_ack = 1'b1;
        reset_n = 1'b0;
        step();
        irq_ack = 1'b0;
        reset_n = 1'b1;
        int_TF0 = 1'b0;
        checkOutput("reset_with_ack_resp", {8'h00, int_resp_n}, 16'h00FF);
        step();
        checkOutput("reset_with_ack_resp2", {8'h00, int_resp_n}, 16'h00FF);

        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
